scan_test_controller: RTL and testbench

SCAN_TEST_CONTROLLER -- requirements
Module: scan_test_controller

---
 rtl/scan_test_controller.sv | 186 ++++++++++++++++++
 tb/tb_scan_test_controller.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/scan_test_controller.sv
// Purpose : drives one scan test (load pattern, functional capture, unload) into an external scan chain.
// Latency : bDone is high in the cycle ending 2*CHAIN_LEN + bCapCycles + 1 rising edges after the bStart edge.
// Backpr. : none; bStart is accepted only while idle and is ignored while bBusy is high.
//
// Ports
//   BrdClk      - clock, all state changes on its rising edge
//   aReset      - synchronous active-high reset; beats a coincident bStart
//   bStart      - one-cycle run request, sampled only in IDLE
//   bLoadData   - pattern shifted into the chain, MSB first
//   bExpect     - expected unload value
//   bCapCycles  - number of scan-disabled (functional) cycles, 0..15
//   bScanEn     - drives the chain's scan enable
//   bScanData   - drives the chain's serial input
//   bScanRet    - chain's serial output (its MSB)
//   bBusy       - high in every state except IDLE
//   bDone       - one-cycle completion pulse
//   bUnload     - chain contents read back, held until the next DONE or reset
//   bPass       - bUnload == latched bExpect, valid from bDone onward
module scan_test_controller #(
    parameter int CHAIN_LEN = 4
) (
    input  logic                 BrdClk,
    input  logic                 aReset,
    input  logic                 bStart,
    input  logic [CHAIN_LEN-1:0] bLoadData,
    input  logic [CHAIN_LEN-1:0] bExpect,
    input  logic [3:0]           bCapCycles,
    output logic                 bScanEn,
    output logic                 bScanData,
    input  logic                 bScanRet,
    output logic                 bBusy,
    output logic                 bDone,
    output logic [CHAIN_LEN-1:0] bUnload,
    output logic                 bPass
);

    // Bit counter is one bit wider than needed to index the chain so that it
    // can never wrap while counting 0..CHAIN_LEN-1.
    localparam int            CW       = $clog2(CHAIN_LEN) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] ONE_BIT  = CW'(1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_UNLOAD  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]           state_q,    state_d;
    logic [CW-1:0]        bit_cnt_q,  bit_cnt_d;
    logic [3:0]           cap_cnt_q,  cap_cnt_d;
    logic [3:0]           caps_q,     caps_d;
    logic [CHAIN_LEN-1:0] pat_q,      pat_d;
    logic [CHAIN_LEN-1:0] expect_q,   expect_d;
    logic [CHAIN_LEN-1:0] shift_q,    shift_d;
    logic [CHAIN_LEN-1:0] unload_q,   unload_d;
    logic                 pass_q,     pass_d;
    logic                 scan_en_q,  scan_en_d;
    logic                 scan_dat_q, scan_dat_d;
    logic                 busy_q,     busy_d;
    logic                 done_q,     done_d;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        cap_cnt_d  = cap_cnt_q;
        caps_d     = caps_q;
        pat_d      = pat_q;
        expect_d   = expect_q;
        shift_d    = shift_q;
        unload_d   = unload_q;
        pass_d     = pass_q;
        scan_dat_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bStart) begin
                    state_d    = S_LOAD;
                    bit_cnt_d  = '0;
                    cap_cnt_d  = '0;
                    caps_d     = bCapCycles;
                    expect_d   = bExpect;
                    shift_d    = '0;
                    // The MSB goes out in the first LOAD cycle; the pattern
                    // register keeps the remaining bits, next one at its MSB.
                    scan_dat_d = bLoadData[CHAIN_LEN-1];
                    pat_d      = bLoadData << 1;
                end
            end

            S_LOAD: begin
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    if (caps_q != 4'd0) begin
                        state_d   = S_CAPTURE;
                        cap_cnt_d = caps_q;
                    end else begin
                        state_d   = S_UNLOAD;
                    end
                end else begin
                    bit_cnt_d  = bit_cnt_q + ONE_BIT;
                    scan_dat_d = pat_q[CHAIN_LEN-1];
                    pat_d      = pat_q << 1;
                end
            end

            S_CAPTURE: begin
                // Counts down to 1 so the state lasts exactly caps_q cycles.
                if (cap_cnt_q == 4'd1) begin
                    state_d   = S_UNLOAD;
                    cap_cnt_d = '0;
                    bit_cnt_d = '0;
                end else begin
                    cap_cnt_d = cap_cnt_q - 4'd1;
                end
            end

            S_UNLOAD: begin
                // The chain MSB appears first, so shifting in at the LSB
                // rebuilds the chain value as it stood on UNLOAD entry.
                shift_d = {shift_q[CHAIN_LEN-2:0], bScanRet};
                if (bit_cnt_q == LAST_BIT) begin
                    state_d   = S_DONE;
                    bit_cnt_d = '0;
                    unload_d  = shift_d;
                    pass_d    = (shift_d == expect_q);
                end else begin
                    bit_cnt_d = bit_cnt_q + ONE_BIT;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the next state.
        scan_en_d = (state_d == S_LOAD) || (state_d == S_UNLOAD);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge BrdClk) begin
        if (aReset) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            cap_cnt_q  <= '0;
            caps_q     <= '0;
            pat_q      <= '0;
            expect_q   <= '0;
            shift_q    <= '0;
            unload_q   <= '0;
            pass_q     <= 1'b0;
            scan_en_q  <= 1'b0;
            scan_dat_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            cap_cnt_q  <= cap_cnt_d;
            caps_q     <= caps_d;
            pat_q      <= pat_d;
            expect_q   <= expect_d;
            shift_q    <= shift_d;
            unload_q   <= unload_d;
            pass_q     <= pass_d;
            scan_en_q  <= scan_en_d;
            scan_dat_q <= scan_dat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bScanEn   = scan_en_q;
    assign bScanData = scan_dat_q;
    assign bBusy     = busy_q;
    assign bDone     = done_q;
    assign bUnload   = unload_q;
    assign bPass     = pass_q;

endmodule

// File: tb/tb_scan_test_controller.sv
module tb_scan_test_controller;

    logic       BrdClk = 1'b0;
    logic       aReset;
    logic       bStart;
    logic [3:0] bLoadData;
    logic [3:0] bExpect;
    logic [3:0] bCapCycles;
    logic       bScanEn;
    logic       bScanData;
    logic       bScanRet;
    logic       bBusy;
    logic       bDone;
    logic [3:0] bUnload;
    logic       bPass;

    int total = 0;
    int bad   = 0;

    always #5 BrdClk = ~BrdClk;

    scan_test_controller #(.CHAIN_LEN(4)) dut (
        .BrdClk     (BrdClk),
        .aReset     (aReset),
        .bStart     (bStart),
        .bLoadData  (bLoadData),
        .bExpect    (bExpect),
        .bCapCycles (bCapCycles),
        .bScanEn    (bScanEn),
        .bScanData  (bScanData),
        .bScanRet   (bScanRet),
        .bBusy      (bBusy),
        .bDone      (bDone),
        .bUnload    (bUnload),
        .bPass      (bPass)
    );

    // Chain under test: a 4-bit up counter with a scan path.
    // Scan mode shifts left with bScanIn at the LSB; otherwise it increments.
    logic [3:0] chain = 4'b0000;
    logic       aIncrement = 1'b1;
    always @(posedge BrdClk) begin
        if (bScanEn)         chain <= {chain[2:0], bScanData};
        else if (aIncrement) chain <= chain + 4'd1;
    end
    assign bScanRet = chain[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge BrdClk);
        #1;
    endtask

    // Runs one test. Edge 0 is the edge that samples bStart; the done edge is
    // the edge that ends the cycle in which bDone is seen high.
    task automatic run_test(input string tag, input logic [3:0] ld, input logic [3:0] cc,
                            input logic [3:0] ex, input int exp_lat, input logic [3:0] exp_un,
                            input logic exp_pass, input bit inject, input bit chk_seq);
        int         done_edge;
        int         done_cnt;
        logic [3:0] un_at_done;
        logic       pass_at_done;
        logic [3:0] seq;
        logic [3:0] en_seq;
        done_edge    = 0;
        done_cnt     = 0;
        un_at_done   = 4'hx;
        pass_at_done = 1'bx;
        seq          = 4'h0;
        en_seq       = 4'h0;
        bLoadData  = ld;
        bCapCycles = cc;
        bExpect    = ex;
        bStart     = 1'b1;
        tick();
        bStart    = 1'b0;
        bLoadData = ~ld;
        bExpect   = ~ex;
        seq[3]    = bScanData;
        en_seq[3] = bScanEn;
        for (int n = 1; n <= 40; n++) begin
            if (inject && n == 2) begin
                bStart     = 1'b1;
                bLoadData  = 4'b0001;
                bCapCycles = 4'd0;
                bExpect    = 4'b0001;
            end
            tick();
            if (inject && n == 2) bStart = 1'b0;
            if (n <= 3) begin
                seq[3-n]    = bScanData;
                en_seq[3-n] = bScanEn;
            end
            if (bDone) begin
                done_cnt++;
                if (done_edge == 0) begin
                    done_edge    = n + 1;
                    un_at_done   = bUnload;
                    pass_at_done = bPass;
                end
            end
        end
        check({tag, " latency"}, done_edge, exp_lat);
        check({tag, " done_pulses"}, done_cnt, 1);
        check({tag, " unload"}, {28'd0, un_at_done}, {28'd0, exp_un});
        check({tag, " pass"}, {31'd0, pass_at_done}, {31'd0, exp_pass});
        check({tag, " unload_hold"}, {28'd0, bUnload}, {28'd0, exp_un});
        check({tag, " idle_busy"}, {31'd0, bBusy}, 32'd0);
        if (chk_seq) begin
            check({tag, " load_seq"}, {28'd0, seq}, {28'd0, ld});
            check({tag, " load_en"}, {28'd0, en_seq}, 32'hF);
        end
    endtask

    initial begin
        int done_seen;
        aReset     = 1'b1;
        bStart     = 1'b0;
        bLoadData  = 4'h0;
        bExpect    = 4'h0;
        bCapCycles = 4'h0;
        tick();
        tick();
        check("rst busy",   {31'd0, bBusy},     32'd0);
        check("rst scanen", {31'd0, bScanEn},   32'd0);
        check("rst scandat",{31'd0, bScanData}, 32'd0);
        check("rst done",   {31'd0, bDone},     32'd0);
        check("rst unload", {28'd0, bUnload},   32'd0);
        check("rst pass",   {31'd0, bPass},     32'd0);

        // Reset wins over a coincident start.
        bStart    = 1'b1;
        bLoadData = 4'b1010;
        tick();
        check("rst_vs_start busy", {31'd0, bBusy}, 32'd0);
        bStart = 1'b0;
        aReset = 1'b0;
        tick();
        check("post_rst idle busy", {31'd0, bBusy}, 32'd0);

        run_test("t1010_c0", 4'b1010, 4'd0,  4'b1010,  9, 4'b1010, 1'b1, 1'b0, 1'b1);
        run_test("t0110_c1", 4'b0110, 4'd1,  4'b0111, 10, 4'b0111, 1'b1, 1'b0, 1'b1);
        run_test("t1111_wrap", 4'b1111, 4'd1, 4'b1111, 10, 4'b0000, 1'b0, 1'b0, 1'b0);
        run_test("t_ignore_start", 4'b0110, 4'd1, 4'b0111, 10, 4'b0111, 1'b1, 1'b1, 1'b1);
        run_test("t0000_c15", 4'b0000, 4'd15, 4'b1111, 24, 4'b1111, 1'b1, 1'b0, 1'b0);

        // Abort during CAPTURE of a 5-cycle capture test.
        bLoadData  = 4'b0011;
        bCapCycles = 4'd5;
        bExpect    = 4'b1000;
        bStart     = 1'b1;
        tick();
        bStart = 1'b0;
        for (int n = 1; n <= 6; n++) tick();
        check("abort pre busy",   {31'd0, bBusy},   32'd1);
        check("abort pre scanen", {31'd0, bScanEn}, 32'd0);
        aReset = 1'b1;
        tick();
        aReset = 1'b0;
        check("abort busy",   {31'd0, bBusy},   32'd0);
        check("abort scanen", {31'd0, bScanEn}, 32'd0);
        check("abort unload", {28'd0, bUnload}, 32'd0);
        check("abort pass",   {31'd0, bPass},   32'd0);
        done_seen = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (bDone) done_seen++;
        end
        check("abort no_done", done_seen, 0);

        run_test("t_after_abort", 4'b0110, 4'd1, 4'b0111, 10, 4'b0111, 1'b1, 1'b0, 1'b0);
        run_test("t_mismatch", 4'b0101, 4'd2, 4'b0101, 11, 4'b0111, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
